// File: rtl/eth_f_mbsync_pkg.sv
// Shared definitions for the multibit toggle-handshake transmitter:
// FSM state encoding, synchronizer depth default, drop-counter width.
package eth_f_mbsync_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } mbsync_state_t;

  localparam int SYNC_DEPTH_DEFAULT = 3;
  localparam int DROP_CNT_W         = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/eth_f_ack_bit_sync.sv
// Single-bit flop-chain synchronizer for the ack toggle coming back from
// the destination domain. DEPTH is legal from 2 to 4.
module eth_f_ack_bit_sync #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;

  // Shift the asynchronous input through DEPTH flops; all clear on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples its neighbour's old value.
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[DEPTH-2:0], d};
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/eth_f_multibit_sync_tx.sv
// Source side of a multibit clock-domain crossing using a toggle
// request/ack handshake. The word is registered and held stable while the
// request toggle is outstanding; the destination samples it once it sees the
// toggle and answers by toggling ack back.
//
// Optional feature: define ETH_F_MBSYNC_CHANGE_DETECT_EN to also launch
// automatically when din differs from the last launched word while idle.
module eth_f_multibit_sync_tx
  import eth_f_mbsync_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SYNC_DEPTH = SYNC_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  send,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      launch_data,
  output logic                  req_tgl,
  input  logic                  ack_tgl_async,
  output logic                  busy,
  output logic                  done,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  mbsync_state_t         state_q, state_next;
  logic [WIDTH-1:0]      launch_data_next;
  logic                  req_tgl_next;
  logic                  done_next;
  logic [DROP_CNT_W-1:0] drop_cnt_next;
  logic                  ack_s;
  logic                  launch_cond;

  // The only consumer of ack_tgl_async.
  eth_f_ack_bit_sync #(
    .DEPTH (SYNC_DEPTH)
  ) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ack_tgl_async),
    .q       (ack_s)
  );

`ifdef ETH_F_MBSYNC_CHANGE_DETECT_EN
  // A new value on din is itself a reason to launch.
  assign launch_cond = send | (din != launch_data);
`else
  assign launch_cond = send;
`endif

  // Next-state and datapath decode. req_tgl only flips on the IDLE->WAIT_ACK
  // edge, and IDLE is only re-entered once ack_s has caught up, so there is
  // never a second toggle while the previous one is outstanding.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_next       = state_q;
    launch_data_next = launch_data;
    req_tgl_next     = req_tgl;
    done_next        = 1'b0;
    drop_cnt_next    = drop_cnt;
    case (state_q)
      ST_IDLE: begin
        if (launch_cond) begin
          launch_data_next = din;
          req_tgl_next     = ~req_tgl;
          state_next       = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_s == req_tgl) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
        // Only explicit send requests are counted; change events are ignored here.
        if (send) drop_cnt_next = sat_inc(drop_cnt);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      launch_data <= '0;
      req_tgl     <= 1'b0;
      done        <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state_q     <= state_next;
      launch_data <= launch_data_next;
      req_tgl     <= req_tgl_next;
      done        <= done_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

  assign busy = (state_q == ST_WAIT_ACK);

endmodule

// File: doc/eth_f_multibit_sync_tx.md
ETH_F_MULTIBIT_SYNC_TX -- requirements
Module: eth_f_multibit_sync_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the width of the transferred word.
REQ-002 SHALL have parameter SYNC_DEPTH, default 3, the flop count of the ack synchronizer (legal 2..4).
REQ-003 SHALL have clk, input, 1 bit, the single source-domain clock.
REQ-004 SHALL have reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have send, input, 1 bit, a request to launch din (sampled each clk).
REQ-006 SHALL have din, input, WIDTH bits, the word to transfer.
REQ-007 SHALL have launch_data, output, WIDTH bits, a registered word, held stable while a transfer is in flight.
REQ-008 SHALL have req_tgl, output, 1 bit, a registered request toggle to the destination domain.
REQ-009 SHALL have ack_tgl_async, input, 1 bit, an ack toggle from the destination domain, asynchronous to clk.
REQ-010 SHALL have busy, output, 1 bit, high while in WAIT_ACK.
REQ-011 SHALL have done, output, 1 bit, a one-cycle pulse when an ack completes a transfer.
REQ-012 SHALL have drop_cnt, output, 8 bits, the saturating count of send requests rejected while busy.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT_ACK.
REQ-014 SHALL, in IDLE with launch condition true at edge N: load launch_data<=din, invert req_tgl, and enter WAIT_ACK, all visible at N+1; busy=1 from N+1.
REQ-015 SHALL pass ack_tgl_async through a SYNC_DEPTH-flop synchronizer to produce ack_s; no other logic samples ack_tgl_async.
REQ-016 SHALL, in WAIT_ACK when ack_s==req_tgl: return to IDLE and pulse done for exactly one cycle, both registered.
REQ-017 SHALL hold launch_data and req_tgl constant throughout WAIT_ACK.
REQ-018 SHALL, on send=1 in WAIT_ACK (including the cycle ack completes), drop the request and increment drop_cnt, saturating at 255.
REQ-019 SHALL accept a new launch in the first IDLE cycle after done, giving a minimum of 2 cycles between launches.
REQ-020 SHALL never change req_tgl more than once per handshake (no toggle while ack_s!=req_tgl).

Reset
REQ-021 SHALL, on reset_n low: state=IDLE; launch_data=0; req_tgl=0; busy=0; done=0; drop_cnt=0; synchronizer flops=0.
REQ-022 SHALL, on reset mid-transfer, abandon the transfer; the destination end is reset in the same reset domain, so no resync is required.
REQ-023 SHALL make the first launch after reset_n deassertion possible at the first clk edge.

Configuration
REQ-024 SHALL support macro ETH_F_MBSYNC_CHANGE_DETECT_EN.
REQ-025 SHALL, with the macro defined, use launch condition = send OR (din != launch_data) in IDLE; a change-triggered event while busy is not counted in drop_cnt.
REQ-026 SHALL, without the macro, use launch condition = send only; no comparator is synthesized.

Structure
REQ-027 SHALL take the FSM state enum, SYNC_DEPTH default, and drop-counter width from shared package eth_f_mbsync_pkg.
REQ-028 SHALL instantiate the ack synchronizer as sub-module eth_f_ack_bit_sync (1-bit, depth parameter, async active-low reset to 0).

Verification
REQ-029 SHALL cover: WIDTH=32, send with din=0xA5A5_0001 at cycle 10 -> launch_data=0xA5A5_0001, req_tgl 0->1, busy=1 at cycle 11.
REQ-030 SHALL cover: ack_tgl_async 0->1 at cycle 20 -> done pulse on exactly one cycle at 20+SYNC_DEPTH+1, busy=0 the same cycle.
REQ-031 SHALL cover: send asserted for 300 cycles while ack is withheld -> drop_cnt=255 (saturated), launch_data unchanged.
REQ-032 SHALL cover: send coincident with the ack completion cycle -> drop_cnt+1; send the next cycle -> a new launch.
REQ-033 SHALL cover: reset_n low during WAIT_ACK -> all outputs 0 asynchronously, state IDLE, then a clean launch after release.
REQ-034 SHALL cover, with the macro defined: din changes 0x0->0x3 with send=0 in IDLE -> auto launch next cycle; din held -> no further launch.
